// File: rtl/mlp_pkg.sv
// Shared types and widths for the MLP weight store / mini-batch update engine.
// No logic; default widths here match the top-level parameter defaults.
// Modules recompute widths from their own parameters via acc_width().
package mlp_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BITS_DEF       = 32;
    localparam int BATCH_LOG2_DEF = 1;
    localparam int ACC_W          = BITS_DEF + 1 + BATCH_LOG2_DEF;

    localparam logic [BITS_DEF-1:0] SAT_MAX = {1'b0, {(BITS_DEF-1){1'b1}}};
    localparam logic [BITS_DEF-1:0] SAT_MIN = {1'b1, {(BITS_DEF-1){1'b0}}};

    // Holds the sum of 2^blog2 deltas, each bits+1 wide, without overflow.
    function automatic int acc_width(input int bits, input int blog2);
        return bits + 1 + blog2;
    endfunction

endpackage

// File: rtl/mlp_row_acc.sv
// One weight row: committed weights, per-word delta accumulators and saturating apply.
// Latency: accumulate/apply/load each take effect at the next posedge.
// Backpressure: none; the parent only strobes one of acc_en / apply_en / ld_we per cycle.
module mlp_row_acc
    import mlp_pkg::*;
#(
    parameter int W          = 7,
    parameter int BITS       = 32,
    parameter int BATCH_LOG2 = 1,
    parameter int COL_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     acc_en,
    input  logic                     apply_en,
    input  logic                     ld_we,
    input  logic [COL_W-1:0]         ld_col,
    input  logic [BITS-1:0]          ld_data,
    input  logic [W-1:0][BITS-1:0]   new_row,
    output logic [W-1:0][BITS-1:0]   w_row
);

    localparam int AW = acc_width(BITS, BATCH_LOG2);

    logic [W-1:0][BITS-1:0] w_q, w_d;
    logic [W-1:0][AW-1:0]   acc_q, acc_d;

    function automatic logic [AW-1:0] acc_add(input logic [AW-1:0]   acc,
                                              input logic [BITS-1:0] nw,
                                              input logic [BITS-1:0] cw);
        logic signed [BITS:0] delta;
        delta = $signed({nw[BITS-1], nw}) - $signed({cw[BITS-1], cw});
        return acc + AW'(delta);
    endfunction

    // Averaged delta fits BITS+1, so the sum fits BITS+2; clamp back to BITS.
    function automatic logic [BITS-1:0] sat_apply(input logic [BITS-1:0] cw,
                                                  input logic [AW-1:0]   acc);
        logic signed [AW-1:0]   avg;
        logic signed [BITS+1:0] sum;
        avg = $signed(acc) >>> BATCH_LOG2;
        sum = (BITS+2)'($signed(cw)) + (BITS+2)'(avg);
        if (!sum[BITS+1] && (sum[BITS:BITS-1] != 2'b00)) return {1'b0, {(BITS-1){1'b1}}};
        if (sum[BITS+1] && (sum[BITS:BITS-1] != 2'b11))  return {1'b1, {(BITS-1){1'b0}}};
        return sum[BITS-1:0];
    endfunction

    always_comb begin
        w_d   = w_q;
        acc_d = acc_q;
        for (int i = 0; i < W; i++) begin
            if (acc_en) begin
                acc_d[i] = acc_add(acc_q[i], new_row[i], w_q[i]);
            end
            if (apply_en) begin
                w_d[i]   = sat_apply(w_q[i], acc_q[i]);
                acc_d[i] = '0;
            end
            if (ld_we && (ld_col == COL_W'(i))) begin
                w_d[i] = ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q   <= '0;
            acc_q <= '0;
        end else begin
            w_q   <= w_d;
            acc_q <= acc_d;
        end
    end

    assign w_row = w_q;

endmodule

// File: rtl/mlp_batch_update.sv
// Weight store and mini-batch gradient-descent update engine for an NX-NH-1 MLP.
// Latency: last accept at t -> rows applied t+1..t+NH+1, batch_done at t+NH+2.
// Backpressure: pat_ready low outside ACC or while ld_en; unready pat_valid is dropped.
module mlp_batch_update
    import mlp_pkg::*;
#(
    parameter int NX         = 6,
    parameter int NH         = 6,
    parameter int BITS       = 32,
    parameter int BATCH_LOG2 = 1,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              pat_valid,
    output logic                              pat_ready,
    input  logic [NH-1:0][NX:0][BITS-1:0]     wh_new,
    input  logic [NH:0][BITS-1:0]             wo_new,
    input  logic                              flush,
    input  logic                              ld_en,
    input  logic [$clog2(NH+1)-1:0]           ld_row,
    input  logic [$clog2(NX+NH+2)-1:0]        ld_col,
    input  logic [BITS-1:0]                   ld_data,
    input  logic                              vl_valid,
    input  logic                              err_in,
    input  logic                              err_clr,
    output logic [NH-1:0][NX:0][BITS-1:0]     w1,
    output logic [NH:0][BITS-1:0]             w2,
    output logic                              busy,
    output logic                              batch_done,
    output logic [CNT_W-1:0]                  err_cnt
);

    localparam int ROW_W = $clog2(NH+1);
    localparam int COL_W = $clog2(NX+NH+2);
    localparam int PC_W  = BATCH_LOG2 + 1;
    localparam logic [PC_W-1:0] BATCH_N = PC_W'(1 << BATCH_LOG2);

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [PC_W-1:0]   pat_cnt_q, pat_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              accept;

    assign pat_ready  = (state_q == ACC) && !ld_en;
    assign accept     = pat_valid && pat_ready;
    assign busy       = (state_q == APPLY);
    assign batch_done = (state_q == DONE);
    assign err_cnt    = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        pat_cnt_d = pat_cnt_q;
        unique case (state_q)
            ACC: begin
                if (accept) pat_cnt_d = pat_cnt_q + 1'b1;
                // A flush in the same cycle as an accept sees the new count.
                if ((pat_cnt_d == BATCH_N) || (flush && (pat_cnt_d != '0))) begin
                    state_d = APPLY;
                    row_d   = '0;
                end
            end
            APPLY: begin
                if (row_q == ROW_W'(NH)) begin
                    state_d   = DONE;
                    row_d     = '0;
                    pat_cnt_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            DONE:    state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (vl_valid && err_in && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ACC;
            row_q     <= '0;
            pat_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            pat_cnt_q <= pat_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    for (genvar r = 0; r <= NH; r++) begin : g_row
        logic apply_en;
        logic ld_we;
        assign apply_en = (state_q == APPLY) && (row_q == ROW_W'(r));
        assign ld_we    = ld_en && (state_q == ACC) && (ld_row == ROW_W'(r));
        if (r < NH) begin : g_hid
            mlp_row_acc #(.W(NX+1), .BITS(BITS), .BATCH_LOG2(BATCH_LOG2), .COL_W(COL_W)) u_row (
                .clk      (clk),
                .rst_n    (rst_n),
                .acc_en   (accept),
                .apply_en (apply_en),
                .ld_we    (ld_we),
                .ld_col   (ld_col),
                .ld_data  (ld_data),
                .new_row  (wh_new[r]),
                .w_row    (w1[r])
            );
        end else begin : g_out
            mlp_row_acc #(.W(NH+1), .BITS(BITS), .BATCH_LOG2(BATCH_LOG2), .COL_W(COL_W)) u_row (
                .clk      (clk),
                .rst_n    (rst_n),
                .acc_en   (accept),
                .apply_en (apply_en),
                .ld_we    (ld_we),
                .ld_col   (ld_col),
                .ld_data  (ld_data),
                .new_row  (wo_new),
                .w_row    (w2)
            );
        end
    end

endmodule

// File: tb/tb_mlp_batch_update.sv
// Randomised bench for mlp_batch_update against a transaction-level weight/accumulator model.
module tb_mlp_batch_update;

    localparam int NX = 6, NH = 6, BITS = 32, BL = 1, CNT_W = 16;
    localparam int BATCH = 1 << BL;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    typedef logic [NH-1:0][NX:0][BITS-1:0] wh_t;
    typedef logic [NH:0][BITS-1:0]         wo_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, pat_valid, pat_ready, flush, ld_en, vl_valid, err_in, err_clr;
    logic busy, batch_done;
    wh_t  wh_new, w1;
    wo_t  wo_new, w2;
    logic [2:0] ld_row;
    logic [3:0] ld_col;
    logic [BITS-1:0]  ld_data;
    logic [CNT_W-1:0] err_cnt;

    mlp_batch_update #(.NX(NX), .NH(NH), .BITS(BITS), .BATCH_LOG2(BL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .wh_new(wh_new), .wo_new(wo_new), .flush(flush), .ld_en(ld_en),
        .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data), .vl_valid(vl_valid),
        .err_in(err_in), .err_clr(err_clr), .w1(w1), .w2(w2), .busy(busy),
        .batch_done(batch_done), .err_cnt(err_cnt)
    );

    longint mw1[NH][NX+1], ma1[NH][NX+1];
    longint mw2[NH+1], ma2[NH+1];
    int     mcnt;
    int     vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [31:0] lo32(input longint v);
        logic [63:0] t;
        t = v;
        return t[31:0];
    endfunction

    function automatic longint sat32(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (mw1[r, c]) begin mw1[r][c] = 0; ma1[r][c] = 0; end
        foreach (mw2[c]) begin mw2[c] = 0; ma2[c] = 0; end
        mcnt = 0;
    endtask

    // Mini-batch rule: w = clamp(w + floor(sum_of_deltas / 2^BL)).
    task automatic model_apply();
        foreach (mw1[r, c]) begin mw1[r][c] = sat32(mw1[r][c] + (ma1[r][c] >>> BL)); ma1[r][c] = 0; end
        foreach (mw2[c]) begin mw2[c] = sat32(mw2[c] + (ma2[c] >>> BL)); ma2[c] = 0; end
        mcnt = 0;
    endtask

    task automatic model_accept(input wh_t wh, input wo_t wo);
        foreach (mw1[r, c]) ma1[r][c] += sx(wh[r][c]) - mw1[r][c];
        foreach (mw2[c]) ma2[c] += sx(wo[c]) - mw2[c];
        mcnt++;
    endtask

    task automatic chk_all(input string tag);
        foreach (mw1[r, c]) chk($sformatf("%s w1[%0d][%0d]", tag, r, c), {32'b0, w1[r][c]}, {32'b0, lo32(mw1[r][c])});
        foreach (mw2[c]) chk($sformatf("%s w2[%0d]", tag, c), {32'b0, w2[c]}, {32'b0, lo32(mw2[c])});
    endtask

    task automatic cur_pat(output wh_t wh, output wo_t wo);
        foreach (mw1[r, c]) wh[r][c] = lo32(mw1[r][c]);
        foreach (mw2[c]) wo[c] = lo32(mw2[c]);
    endtask

    function automatic logic [31:0] rnd_word(input longint cur);
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return $urandom();
            default: return lo32(cur + longint'($urandom_range(0, 1023)) - 512);
        endcase
    endfunction

    task automatic rnd_pat(output wh_t wh, output wo_t wo);
        foreach (mw1[r, c]) wh[r][c] = rnd_word(mw1[r][c]);
        foreach (mw2[c]) wo[c] = rnd_word(mw2[c]);
    endtask

    task automatic wait_batch();
        int n;
        n = 1;
        chk("busy_in_apply", {63'b0, busy}, 64'd1);
        while (!batch_done && n < 40) begin tick(); n++; end
        chk("done_latency", 64'(n), 64'(NH + 2));
        chk("pat_ready_in_done", {63'b0, pat_ready}, 64'd0);
        model_apply();
        tick();
        chk("done_one_cycle", {63'b0, batch_done}, 64'd0);
        chk("pat_ready_back", {63'b0, pat_ready}, 64'd1);
        chk_all("post_batch");
    endtask

    task automatic send_pat(input wh_t wh, input wo_t wo, input logic fl);
        wh_new = wh; wo_new = wo; flush = fl; pat_valid = 1'b1;
        #1;
        chk("pat_ready_acc", {63'b0, pat_ready}, 64'd1);
        model_accept(wh, wo);
        tick();
        pat_valid = 1'b0; flush = 1'b0;
        if (mcnt == BATCH || (fl && mcnt > 0)) wait_batch();
        else chk("busy_mid_batch", {63'b0, busy}, 64'd0);
    endtask

    task automatic send_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (mcnt > 0) wait_batch();
        else chk("flush_empty_ignored", {63'b0, busy}, 64'd0);
    endtask

    task automatic do_load(input int r, input int c, input logic [31:0] d, input logic with_pat);
        wh_t wh; wo_t wo;
        rnd_pat(wh, wo);
        wh_new = wh; wo_new = wo; pat_valid = with_pat;
        ld_en = 1'b1; ld_row = 3'(r); ld_col = 4'(c); ld_data = d;
        #1;
        chk("pat_ready_during_ld", {63'b0, pat_ready}, 64'd0);
        tick();
        ld_en = 1'b0; pat_valid = 1'b0;
        if (r < NH && c <= NX) mw1[r][c] = sx(d);
        else if (r == NH && c <= NH) mw2[c] = sx(d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wh_t wh; wo_t wo;
        int  merr;
        rst_n = 1'b0; pat_valid = 1'b0; flush = 1'b0; ld_en = 1'b0; ld_row = '0; ld_col = '0;
        ld_data = '0; vl_valid = 1'b0; err_in = 1'b0; err_clr = 1'b0; wh_new = '0; wo_new = '0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        chk_all("reset");
        chk("reset_pat_ready", {63'b0, pat_ready}, 64'd1);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_batch_done", {63'b0, batch_done}, 64'd0);
        chk("reset_err_cnt", 64'(err_cnt), 64'd0);

        // Averaging of two patterns.
        do_load(0, 0, 32'h100, 1'b0);
        cur_pat(wh, wo); wh[0][0] = 32'h140; send_pat(wh, wo, 1'b0);
        cur_pat(wh, wo); wh[0][0] = 32'h180; send_pat(wh, wo, 1'b0);
        chk("avg_w1_0_0", {32'b0, w1[0][0]}, 64'h160);

        // Positive and negative saturation, using a load between patterns.
        cur_pat(wh, wo); wo[0] = 32'h7FFF_FFFF; wo[1] = 32'h8000_0000; send_pat(wh, wo, 1'b0);
        do_load(NH, 0, 32'h7FFF_FFF0, 1'b0);
        do_load(NH, 1, 32'h8000_0010, 1'b0);
        cur_pat(wh, wo); wo[0] = 32'h7FFF_FFFF; wo[1] = 32'h8000_0000; send_pat(wh, wo, 1'b0);
        chk("sat_pos_w2_0", {32'b0, w2[0]}, 64'h7FFF_FFFF);
        chk("sat_neg_w2_1", {32'b0, w2[1]}, 64'h8000_0000);

        // Partial batch flushed, still halved; then an empty flush is ignored.
        cur_pat(wh, wo); wh[2][3] = lo32(mw1[2][3] + 64'h40); send_pat(wh, wo, 1'b0);
        send_flush();
        chk("flush_w1_2_3", {32'b0, w1[2][3]}, 64'h20);
        send_flush();

        // Load wins over a simultaneous pattern; the pattern is not counted.
        do_load(3, 4, 32'h1234, 1'b1);
        chk("ld_vs_pat_w1_3_4", {32'b0, w1[3][4]}, 64'h1234);
        cur_pat(wh, wo); wh[3][4] = 32'h1274; send_pat(wh, wo, 1'b1);
        chk("ld_vs_pat_single", {32'b0, w1[3][4]}, 64'h1254);

        // Randomised mix of loads, patterns and flushes.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1: do_load($urandom_range(0, 7), $urandom_range(0, 15), $urandom(), 1'b0);
                2:    do_load($urandom_range(0, NH), $urandom_range(0, NX), $urandom(), 1'b1);
                3:    send_flush();
                4:    begin rnd_pat(wh, wo); send_pat(wh, wo, 1'b1); end
                default: begin rnd_pat(wh, wo); send_pat(wh, wo, 1'b0); end
            endcase
            if (i % 10 == 0) chk_all("rand_acc");
        end

        // Reset in the middle of the apply sweep.
        if (mcnt == 0) begin rnd_pat(wh, wo); send_pat(wh, wo, 1'b0); end
        rnd_pat(wh, wo);
        wh_new = wh; wo_new = wo; pat_valid = 1'b1;
        tick();
        pat_valid = 1'b0;
        tick(); tick(); tick();
        chk("busy_before_rst", {63'b0, busy}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        chk_all("mid_apply_reset");
        chk("rst_pat_ready", {63'b0, pat_ready}, 64'd1);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        tick();
        chk("rst_no_done", {63'b0, batch_done}, 64'd0);

        // Validation error counter.
        merr = 0;
        for (int i = 0; i < 16; i++) begin
            vl_valid = 1'($urandom_range(0, 1));
            err_in   = 1'($urandom_range(0, 1));
            if (vl_valid && err_in) merr++;
            tick();
        end
        vl_valid = 1'b1; err_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        merr += 5;
        vl_valid = 1'b0; err_in = 1'b0;
        chk("err_cnt_count", 64'(err_cnt), 64'(merr));
        err_clr = 1'b1; vl_valid = 1'b1; err_in = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr_priority", 64'(err_cnt), 64'd0);
        tick();
        vl_valid = 1'b0; err_in = 1'b0;
        chk("err_cnt_after_clr", 64'(err_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
